// File: rtl/register_file_pkg.sv
// Shared constants and helpers for the architectural register file.
package register_file_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int REG_COUNT  = 32;
   localparam int CNT_W      = 16;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
   localparam logic [REG_ADDR_W-1:0] LINK_REG = 5'd31;

   // Saturating increment for the committed-write counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/regfile_bypass.sv
// One read port: forwards the in-flight write-back data when the read address
// matches a write that will commit this edge, otherwise passes array contents.
module regfile_bypass
   import register_file_pkg::*;
#(
   parameter int DATA_W = register_file_pkg::DATA_W
) (
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0]     arr_data,
   input  logic                  wr_valid,
   input  logic [REG_ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   output logic [DATA_W-1:0]     rd_data
);

   logic w_hit;

   // wr_valid already excludes register 0, so r0 never picks up forwarded data.
   assign w_hit   = wr_valid && (rd_addr == wr_addr);
   assign rd_data = w_hit ? wr_data : arr_data;

endmodule

// File: rtl/register_file.sv
// Architectural register file: two bypassed read ports, one unbypassed debug
// read port, one write-back port and a saturating committed-write counter.
module register_file
   import register_file_pkg::*;
#(
   parameter int DATA_W    = register_file_pkg::DATA_W,
   parameter int REG_COUNT = register_file_pkg::REG_COUNT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] rs_addr,
   input  logic [REG_ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0]     rs_data,
   output logic [DATA_W-1:0]     rt_data,
   input  logic                  wr_en,
   input  logic [REG_ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0]     dbg_data,
   output logic [CNT_W-1:0]      wr_count
);

   logic [DATA_W-1:0] r_regs [REG_COUNT];
   logic [CNT_W-1:0]  r_wr_count;

   logic              w_wr_commit;
   logic [DATA_W-1:0] w_rs_arr;
   logic [DATA_W-1:0] w_rt_arr;

   // Register 0 and addresses beyond REG_COUNT read as zero.
   function automatic logic [DATA_W-1:0] arr_rd(input logic [REG_ADDR_W-1:0] a);
      if (a == ZERO_REG || int'(a) >= REG_COUNT) return '0;
      return r_regs[a];
   endfunction

   assign w_wr_commit = wr_en && (wr_addr != ZERO_REG) && (int'(wr_addr) < REG_COUNT);

   assign w_rs_arr = arr_rd(rs_addr);
   assign w_rt_arr = arr_rd(rt_addr);
   assign dbg_data = arr_rd(dbg_addr);
   assign wr_count = r_wr_count;

   regfile_bypass #(.DATA_W(DATA_W)) u_rs_bypass (
      .rd_addr  (rs_addr),
      .arr_data (w_rs_arr),
      .wr_valid (w_wr_commit),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rs_data)
   );

   regfile_bypass #(.DATA_W(DATA_W)) u_rt_bypass (
      .rd_addr  (rt_addr),
      .arr_data (w_rt_arr),
      .wr_valid (w_wr_commit),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rt_data)
   );

   // Reset wins over a same-cycle write; the write is neither stored nor counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
         r_wr_count <= '0;
      end else if (w_wr_commit) begin
         r_regs[wr_addr] <= wr_data;
         r_wr_count      <= sat_inc(r_wr_count);
      end
   end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter REG_COUNT, default 32, meaning number of architectural registers; address width is fixed at 5.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the synchronous active-high reset sampled on rising clk.
REQ-005 The block SHALL have port rs_addr, input, 5, the first read address.
REQ-006 The block SHALL have port rt_addr, input, 5, the second read address.
REQ-007 The block SHALL have port rs_data, output, DATA_W, the first read data.
REQ-008 The block SHALL have port rt_data, output, DATA_W, the second read data.
REQ-009 The block SHALL have port wr_en, input, 1, the write-back enable.
REQ-010 The block SHALL have port wr_addr, input, 5, the write-back destination, driven by the 5-bit write-address select stage (link writes arrive as 31).
REQ-011 The block SHALL have port wr_data, input, DATA_W, the write-back data.
REQ-012 The block SHALL have port dbg_addr, input, 5, the debug read address.
REQ-013 The block SHALL have port dbg_data, output, DATA_W, the debug read data (no bypass).
REQ-014 The block SHALL have port wr_count, output, 16, the number of committed writes since reset.

Function
REQ-015 The block SHALL return rs_data, rt_data and dbg_data combinationally from the register array in the same cycle the address is applied.
REQ-016 The block SHALL commit wr_data to register wr_addr on a rising clk when wr_en=1 and rst=0; write latency is one edge.
REQ-017 Register 0 SHALL read as 0 on all ports; writes to register 0 SHALL be discarded and SHALL NOT increment wr_count.
REQ-018 The block SHALL bypass: when wr_en=1, wr_addr!=0 and rs_addr==wr_addr, rs_data SHALL equal wr_data in that cycle; rt_data likewise.
REQ-019 When both read ports address the write target, both SHALL bypass simultaneously.
REQ-020 dbg_data SHALL show only committed contents, never bypassed data.
REQ-021 wr_count SHALL increment by 1 per committed non-zero-address write and SHALL saturate at 16'hFFFF.
REQ-022 Back-to-back writes to the same address SHALL leave the last value; each SHALL count.
REQ-023 Writes to register 31 SHALL be treated identically to any other register (no special link logic inside this block).

Reset
REQ-024 On rst=1 at a rising clk, all registers SHALL clear to 0 and wr_count SHALL clear to 0.
REQ-025 rst SHALL take priority over wr_en in the same cycle; the pending write is lost and not counted.
REQ-026 During rst=1, read ports and bypass SHALL remain combinational; after the clearing edge all reads SHALL return 0.

Structure
REQ-027 A shared package SHALL hold REG_ADDR_W=5, DATA_W=32, REG_COUNT=32, ZERO_REG=5'd0 and LINK_REG=5'd31.
REQ-028 One sub-module, regfile_bypass, SHALL implement the per-port address compare and select; it SHALL be instantiated twice (rs, rt).

Verification
REQ-029 Reset then read all 32 addresses on rs, rt, dbg -> all return 0, wr_count=0.
REQ-030 Write 32'hDEADBEEF to r5, same cycle rs_addr=5 -> rs_data=DEADBEEF, dbg_data(5)=0; next cycle dbg_data(5)=DEADBEEF, wr_count=1.
REQ-031 Write 32'h12345678 to r0, rs_addr=rt_addr=0 -> both read 0 that cycle and after, wr_count unchanged.
REQ-032 Write 32'h0000_1004 to r31 with rs_addr=rt_addr=31 -> both ports return 0x1004 same cycle; r31 holds it afterwards.
REQ-033 wr_en=1, wr_addr=7, wr_data=32'hA5A5A5A5 with rst=1 -> r7 reads 0 next cycle, wr_count=0.
REQ-034 Force 65540 writes to r1 -> wr_count holds 16'hFFFF; r1 holds the last data written.
